// File: rtl/input_debounce_pkg.sv
// Shared constants and helpers for the input_debounce block.
//   clog2                     : ceiling log2, used to size the debounce counters
//   DEFAULT_DEBOUNCE_CYCLES   : default number of stable cycles before a level change
package input_debounce_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000;

  // Ceiling log2 over a 32-bit range; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/input_debounce_if.sv
// Bundle of raw inputs, mode control and conditioned outputs for input_debounce.
//   in          : raw asynchronous inputs, one bit per channel
//   debounce_en : 1 = filter active, 0 = bypass filter
//   level       : debounced level per channel
//   rise / fall : one-cycle strobes when level goes 0->1 / 1->0
//   change      : OR of all rise and fall bits, same cycle
// master = the side driving raw inputs, slave = the conditioner.
interface input_debounce_if #(
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0] in;
  logic                debounce_en;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                change;

  modport master (
    output in,
    output debounce_en,
    input  level,
    input  rise,
    input  fall,
    input  change
  );

  modport slave (
    input  in,
    input  debounce_en,
    output level,
    output rise,
    output fall,
    output change
  );
endinterface

// File: rtl/input_debounce_channel.sv
// Single-bit input conditioner: synchroniser chain, stability counter,
// registered level and one-cycle rise/fall strobes.
//   clk, reset_n  : core clock, async active-low reset
//   din           : raw asynchronous input bit
//   debounce_en   : 1 = require DEBOUNCE_CYCLES stable cycles, 0 = bypass
//   level         : registered debounced level
//   rise, fall    : registered one-cycle strobes
//   rise_c, fall_c: next-cycle strobe values, so the parent can register an
//                   aggregate in the same cycle as the strobes
module debounce_channel
  import input_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic debounce_en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: din enters at bit 0, s is the last stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Stability filter: any sample equal to level clears the count, so only an
  // unbroken run of differing samples can move the level. Bypass keeps the
  // count at zero and commits on the first differing sample.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    if (s != level_q) begin
      if (!debounce_en || (cnt_q == CW'(DEBOUNCE_CYCLES - 1))) begin
        level_d = s;
        rise_c  = s;
        fall_c  = !s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter, level and strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_c;
      fall_q  <= fall_c;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input conditioner. Each channel is synchronised into the core
// clock domain, debounced, and reported as a registered level with one-cycle
// rise/fall strobes; change flags any strobe in the same cycle.
//   clk     : core clock
//   reset_n : async active-low reset
//   bus     : slave side of input_debounce_if (in, debounce_en -> level,
//             rise, fall, change)
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          INIT_LEVEL      = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input_debounce_if.slave  bus
);

  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] rise_c;
  logic [CHANNELS-1:0] fall_c;
  logic                change_q;

  // One independent conditioner per input bit.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT_LEVEL      (INIT_LEVEL)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .din         (bus.in[i]),
      .debounce_en (bus.debounce_en),
      .level       (level[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .rise_c      (rise_c[i]),
      .fall_c      (fall_c[i])
    );
  end

  // Built from next-cycle strobes so change lands in the same cycle as them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) change_q <= 1'b0;
    else          change_q <= |(rise_c | fall_c);
  end

  assign bus.level  = level;
  assign bus.rise   = rise;
  assign bus.fall   = fall;
  assign bus.change = change_q;

endmodule

// File: tb/tb_input_debounce.sv
// Scenario bench for input_debounce (4 channels, 2 sync stages, 4-cycle
// filter). Each scenario pushes the strobe events it expects, stamped with
// the cycle they are due; every cycle either pops a due event and compares
// it, or requires a quiet cycle at the last expected level.
module tb_input_debounce;
  import input_debounce_pkg::*;

  localparam int unsigned CH = 4;

  typedef struct {
    int unsigned at_cyc;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          change;
  } ev_t;

  logic clk;
  logic reset_n;
  int unsigned cyc;
  int errors;
  int checks;
  logic [CH-1:0] exp_level;
  ev_t sb[$];

  input_debounce_if #(.CHANNELS(CH)) bus ();

  input_debounce #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .INIT_LEVEL      (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_ev(input int unsigned dly, input logic [CH-1:0] lvl,
                         input logic [CH-1:0] r, input logic [CH-1:0] f);
    ev_t ev;
    ev.at_cyc = cyc + dly;
    ev.level  = lvl;
    ev.rise   = r;
    ev.fall   = f;
    ev.change = |(r | f);
    sb.push_back(ev);
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run_cycles(input int n);
    ev_t ev;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0 && sb[0].at_cyc == cyc) begin
        ev = sb.pop_front();
        checks++;
        if ({bus.level, bus.rise, bus.fall, bus.change} !==
            {ev.level, ev.rise, ev.fall, ev.change}) begin
          errors++;
          $display("FAIL event@%0d: level=%b rise=%b fall=%b change=%b, want level=%b rise=%b fall=%b change=%b",
                   cyc, bus.level, bus.rise, bus.fall, bus.change,
                   ev.level, ev.rise, ev.fall, ev.change);
        end
        exp_level = ev.level;
      end else begin
        checks++;
        if (bus.level !== exp_level || bus.rise !== '0 || bus.fall !== '0 ||
            bus.change !== 1'b0) begin
          errors++;
          $display("FAIL quiet@%0d: level=%b rise=%b fall=%b change=%b, want level=%b and no strobe",
                   cyc, bus.level, bus.rise, bus.fall, bus.change, exp_level);
        end
      end
    end
  endtask

  task automatic expect_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drained: %0d events outstanding, want 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset;
    reset_n         = 1'b1;
    bus.in          = '0;
    bus.debounce_en = 1'b1;
    #2;
    reset_n = 1'b0;
    bus.in  = 4'b1111;
    #1;
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.change} !== 13'b0) begin
      errors++;
      $display("FAIL reset async: level=%b rise=%b fall=%b change=%b, want all 0",
               bus.level, bus.rise, bus.fall, bus.change);
    end
    exp_level = '0;
    run_cycles(3);
    reset_n = 1'b1;
    push_ev(6, 4'b1111, 4'b1111, 4'b0000);
    run_cycles(8);
    expect_drained("reset");
  endtask

  task automatic test_glitch;
    bus.in = 4'b0000;
    push_ev(6, 4'b0000, 4'b0000, 4'b1111);
    run_cycles(8);
    bus.in[0] = 1'b1;
    run_cycles(3);
    bus.in[0] = 1'b0;
    run_cycles(8);
    bus.in[0] = 1'b1;
    push_ev(6, 4'b0001, 4'b0001, 4'b0000);
    run_cycles(8);
    bus.in[0] = 1'b0;
    push_ev(6, 4'b0000, 4'b0000, 4'b0001);
    run_cycles(8);
    expect_drained("glitch");
  endtask

  task automatic test_clean_edges;
    bus.in = 4'b0010;
    push_ev(6, 4'b0010, 4'b0010, 4'b0000);
    run_cycles(8);
    bus.in = 4'b0000;
    push_ev(6, 4'b0000, 4'b0000, 4'b0010);
    run_cycles(8);
    expect_drained("clean_edges");
  endtask

  task automatic test_simultaneous;
    bus.in = 4'b0010;
    push_ev(6, 4'b0010, 4'b0010, 4'b0000);
    run_cycles(8);
    bus.in = 4'b0001;
    push_ev(6, 4'b0001, 4'b0001, 4'b0010);
    run_cycles(8);
    expect_drained("simultaneous");
  endtask

  task automatic test_bypass;
    bus.debounce_en = 1'b0;
    bus.in = 4'b0101;
    push_ev(3, 4'b0101, 4'b0100, 4'b0000);
    push_ev(4, 4'b0001, 4'b0000, 4'b0100);
    run_cycles(1);
    bus.in = 4'b0001;
    run_cycles(6);
    bus.debounce_en = 1'b1;
    run_cycles(2);
    expect_drained("bypass");
  endtask

  task automatic test_midcount_reset;
    bus.in = 4'b1001;
    run_cycles(4);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.change} !== 13'b0) begin
      errors++;
      $display("FAIL midcount async: level=%b rise=%b fall=%b change=%b, want all 0",
               bus.level, bus.rise, bus.fall, bus.change);
    end
    exp_level = '0;
    run_cycles(3);
    reset_n = 1'b1;
    push_ev(6, 4'b1001, 4'b1001, 4'b0000);
    run_cycles(8);
    expect_drained("midcount_reset");
  endtask

  initial begin
    cyc    = 0;
    errors = 0;
    checks = 0;
    test_reset();
    test_glitch();
    test_clean_edges();
    test_simultaneous();
    test_bypass();
    test_midcount_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Multi-channel input conditioner: per-channel synchroniser, debounce filter, registered level plus one-cycle rise/fall strobes.
- Parametrised successor to the single-bit edge detector; adds synchronisation, glitch rejection, a bypass mode and N-channel width.
- Sits between raw board inputs (buttons, HPD, strap pins) and control FSMs in the core clock domain.

Parameters:
CHANNELS, 8, number of independent input bits (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before level changes (>=1)
INIT_LEVEL, 0, reset value of sync flops and level for every channel (1-bit, applied to all channels)

Ports:
clk  input  1  core clock; all state on posedge
reset_n  input  1  asynchronous, active-low reset
in  input  CHANNELS  raw asynchronous inputs
debounce_en  input  1  1 = filter active; 0 = bypass filter, level follows synchronised input
level  output  CHANNELS  registered debounced level
rise  output  CHANNELS  one-cycle strobe, high in the cycle level goes 0->1
fall  output  CHANNELS  one-cycle strobe, high in the cycle level goes 1->0
change  output  1  registered OR of all rise and fall bits

Behaviour:
- Reset (reset_n low, async): sync chain = INIT_LEVEL, level = INIT_LEVEL, counters = 0, rise = fall = 0, change = 0. Outputs take reset values immediately; no clock needed.
- Reset release produces no pulse by itself. If the input differs from INIT_LEVEL, it is reported as a normal transition after the full latency.
- Sync: in[i] passes through SYNC_STAGES flops; s[i] is the last flop's output.
- Per-channel counter, width clog2(DEBOUNCE_CYCLES+1):
  - s == level: counter <= 0 (glitch rejected).
  - s != level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != level and counter == DEBOUNCE_CYCLES-1: level <= s, counter <= 0, rise/fall set per new value.
- Latency: if in changes before edge 1 and stays stable, s updates at edge SYNC_STAGES and level updates at edge SYNC_STAGES+DEBOUNCE_CYCLES. rise/fall assert in that same cycle, for exactly one cycle.
- Bypass (debounce_en=0): counters held at 0; level <= s on every edge where they differ, with strobes. Latency is SYNC_STAGES+1, identical to DEBOUNCE_CYCLES=1.
- debounce_en toggled mid-count: the count restarts from 0; no spurious strobe.
- Glitch shorter than DEBOUNCE_CYCLES after synchronisation: no level change, no strobe.
- Channels are fully independent. Any mix of rise/fall bits may assert in one cycle. change is registered alongside them (same cycle).
- rise and fall for one channel are never high together. A channel cannot produce two strobes closer than DEBOUNCE_CYCLES cycles (1 in bypass).

Decomposition:
- Shared util package/include: clog2 width helper constant function and default DEBOUNCE_CYCLES constant. No typedefs needed.
- One sub-module, debounce_channel: single-bit sync chain, counter, level, rise, fall. Top level instantiates CHANNELS copies with a generate loop and ORs strobes into change.

Test Plan (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=0, debounce_en=1 unless stated):
- Reset: hold reset_n=0 with in=4'b1111 -> level=0, rise=0, change=0. Release -> rise=4'b1111, change=1 for one cycle at edge 6 after release; level=4'b1111 thereafter.
- Glitch: in[0] high 3 cycles then low -> level[0] stays 0, rise[0] never asserts. High 4+ cycles -> rise[0] at edge 6 after the change.
- Clean edges: in[1] 0->1 -> rise[1]=1 for exactly one cycle at edge 6. in[1] 1->0 later -> fall[1] one cycle at edge 6.
- Bypass: debounce_en=0, in[2] high for 1 cycle -> level[2]=1 at edge 3, rise[2] at edge 3, fall[2] at edge 4.
- Mid-count reset: in[3] rises, pull reset_n low between edges 4 and 5 -> level, rise, fall = 0 immediately (async), no strobe before or after release until full latency elapses.
- Simultaneous: level=4'b0010, then in[0] 0->1 and in[1] 1->0 on the same cycle -> rise=4'b0001, fall=4'b0010, change=1, all in the same cycle.
